// File: rtl/fa_serial_sequencer_if.sv
// Bundle of every non-clock signal around fa_serial_sequencer.
// The host side (start/op_a/op_b/cin in, busy/done/result/cout out) and the
// full_adder side (fa_a/fa_b/fa_cin out, fa_sum/fa_cout in) travel together.
//   slave  : the sequencer's view
//   master : the environment's view (host plus the full_adder cell)
interface fa_serial_sequencer_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             cout;
   logic             fa_a;
   logic             fa_b;
   logic             fa_cin;
   logic             fa_sum;
   logic             fa_cout;

   modport slave (
      input  start, op_a, op_b, cin, fa_sum, fa_cout,
      output busy, done, result, cout, fa_a, fa_b, fa_cin
   );

   modport master (
      output start, op_a, op_b, cin, fa_sum, fa_cout,
      input  busy, done, result, cout, fa_a, fa_b, fa_cin
   );
endinterface

// File: rtl/fa_serial_sequencer.sv
// Bit-serial sequencer for a single full_adder cell.
// Accepts two WIDTH-bit operands and a carry-in, then walks the adder one bit
// per window of FA_LATENCY cycles, feeding each captured carry into the next
// bit. Result and final carry come back with a one-cycle done pulse.
// Ports:
//   clk_i    system clock, rising edge
//   reset_i  synchronous, active-high reset
//   bus_if   host handshake/operands/result plus the full_adder connections
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for start
// S_WAIT | adder inputs held for the current bit, wait counter running
// S_DONE | one-cycle done pulse; a new start is accepted here too
module fa_serial_sequencer #(
   parameter int WIDTH      = 8,
   parameter int FA_LATENCY = 6
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   fa_serial_sequencer_if.slave     bus_if
);

   localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int CNT_W = (FA_LATENCY > 1) ? $clog2(FA_LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FA_LATENCY - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
   logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic [WIDTH-1:0]   op_a_q, op_a_d;
   logic [WIDTH-1:0]   op_b_q, op_b_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               cout_q, cout_d;
   logic               fa_a_q, fa_a_d;
   logic               fa_b_q, fa_b_d;
   logic               fa_cin_q, fa_cin_d;
   logic [IDX_W-1:0]   bit_idx_inc;

   assign bit_idx_inc = bit_idx_q + IDX_W'(1);

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= S_IDLE;
         bit_idx_q  <= '0;
         wait_cnt_q <= '0;
         op_a_q     <= '0;
         op_b_q     <= '0;
         result_q   <= '0;
         cout_q     <= 1'b0;
         fa_a_q     <= 1'b0;
         fa_b_q     <= 1'b0;
         fa_cin_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_idx_q  <= bit_idx_d;
         wait_cnt_q <= wait_cnt_d;
         op_a_q     <= op_a_d;
         op_b_q     <= op_b_d;
         result_q   <= result_d;
         cout_q     <= cout_d;
         fa_a_q     <= fa_a_d;
         fa_b_q     <= fa_b_d;
         fa_cin_q   <= fa_cin_d;
      end
   end

   // The adder inputs are loaded one edge ahead of each bit window, so they
   // are already stable on the first cycle of the window. fa_cin_q doubles as
   // the latched carry-in for bit 0 and the captured carry for later bits.
   always_comb begin
      state_d    = state_q;
      bit_idx_d  = bit_idx_q;
      wait_cnt_d = wait_cnt_q;
      op_a_d     = op_a_q;
      op_b_d     = op_b_q;
      result_d   = result_q;
      cout_d     = cout_q;
      fa_a_d     = fa_a_q;
      fa_b_d     = fa_b_q;
      fa_cin_d   = fa_cin_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            fa_a_d   = 1'b0;
            fa_b_d   = 1'b0;
            fa_cin_d = 1'b0;
            if (bus_if.start) begin
               op_a_d     = bus_if.op_a;
               op_b_d     = bus_if.op_b;
               bit_idx_d  = '0;
               wait_cnt_d = CNT_LOAD;
               fa_a_d     = bus_if.op_a[0];
               fa_b_d     = bus_if.op_b[0];
               fa_cin_d   = bus_if.cin;
               state_d    = S_WAIT;
            end else begin
               state_d = S_IDLE;
            end
         end

         S_WAIT: begin
            if (wait_cnt_q != '0) begin
               wait_cnt_d = wait_cnt_q - CNT_W'(1);
            end else begin
               result_d[bit_idx_q] = bus_if.fa_sum;
               if (bit_idx_q == IDX_LAST) begin
                  cout_d   = bus_if.fa_cout;
                  fa_a_d   = 1'b0;
                  fa_b_d   = 1'b0;
                  fa_cin_d = 1'b0;
                  state_d  = S_DONE;
               end else begin
                  bit_idx_d  = bit_idx_inc;
                  wait_cnt_d = CNT_LOAD;
                  fa_a_d     = op_a_q[bit_idx_inc];
                  fa_b_d     = op_b_q[bit_idx_inc];
                  fa_cin_d   = bus_if.fa_cout;
               end
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign bus_if.busy   = (state_q == S_WAIT);
   assign bus_if.done   = (state_q == S_DONE);
   assign bus_if.result = result_q;
   assign bus_if.cout   = cout_q;
   assign bus_if.fa_a   = fa_a_q;
   assign bus_if.fa_b   = fa_b_q;
   assign bus_if.fa_cin = fa_cin_q;

endmodule

// File: tb/tb_fa_serial_sequencer.sv
module tb_fa_serial_sequencer;

   localparam int W   = 8;
   localparam int LAT = 6;
   localparam int DONE_CYC = W * LAT + 1;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   tests = 0;
   int   fails = 0;

   fa_serial_sequencer_if #(.WIDTH(W)) bus ();

   fa_serial_sequencer #(.WIDTH(W), .FA_LATENCY(LAT)) dut (
      .clk_i   (clk),
      .reset_i (reset),
      .bus_if  (bus)
   );

   always #5 clk = ~clk;

   // Behavioural full adder: outputs follow inputs after 5 clock edges.
   logic [1:0] fa_pipe [5] = '{default: 2'b00};
   always @(posedge clk) begin
      fa_pipe[4] <= fa_pipe[3];
      fa_pipe[3] <= fa_pipe[2];
      fa_pipe[2] <= fa_pipe[1];
      fa_pipe[1] <= fa_pipe[0];
      fa_pipe[0] <= {(bus.fa_a & bus.fa_b) | (bus.fa_a & bus.fa_cin) | (bus.fa_b & bus.fa_cin),
                     bus.fa_a ^ bus.fa_b ^ bus.fa_cin};
   end
   assign bus.fa_sum  = fa_pipe[4][0];
   assign bus.fa_cout = fa_pipe[4][1];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive an accepted request; returns at the sampling point of cycle 1.
   task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic c);
      bus.start = 1'b1;
      bus.op_a  = a;
      bus.op_b  = b;
      bus.cin   = c;
      @(negedge clk);
   endtask

   // Walks one operation from cycle 1 to the done cycle. p1/p2: cycles with an
   // extra (ignored) start pulse; rst_at: cycle in which reset is asserted;
   // chain: hold start with the next operands through the done cycle.
   task automatic check_op(input logic [7:0] a, input logic [7:0] b, input logic c,
                           input int p1, input int p2, input int rst_at,
                           input bit chain, input logic [7:0] na, input logic [7:0] nb,
                           input logic nc);
      int full;
      int bi;
      int mask;
      int carry;
      full = int'(a) + int'(b) + int'(c);
      for (int k = 1; k <= DONE_CYC; k++) begin
         if (rst_at != 0 && k == rst_at + 1) begin
            chk("rst_busy",   32'(bus.busy),   32'd0);
            chk("rst_done",   32'(bus.done),   32'd0);
            chk("rst_result", 32'(bus.result), 32'd0);
            chk("rst_cout",   32'(bus.cout),   32'd0);
            chk("rst_fa",     32'({bus.fa_a, bus.fa_b, bus.fa_cin}), 32'd0);
            reset = 1'b0;
            for (int j = 0; j < 60; j++) begin
               @(negedge clk);
               if (bus.done !== 1'b0) chk("rst_no_done", 32'(bus.done), 32'd0);
            end
            chk("rst_stays_idle", 32'(bus.busy), 32'd0);
            return;
         end
         if (k < DONE_CYC) begin
            bi    = (k - 1) / LAT;
            mask  = (1 << bi) - 1;
            carry = ((int'(a) & mask) + (int'(b) & mask) + int'(c)) >> bi;
            chk("busy",   32'(bus.busy),   32'd1);
            chk("done_lo", 32'(bus.done),  32'd0);
            chk("fa_a",   32'(bus.fa_a),   32'(a[bi]));
            chk("fa_b",   32'(bus.fa_b),   32'(b[bi]));
            chk("fa_cin", 32'(bus.fa_cin), 32'(carry & 1));
         end else begin
            chk("done",   32'(bus.done),   32'd1);
            chk("busy_done", 32'(bus.busy), 32'd0);
            chk("result", 32'(bus.result), 32'(full & 8'hFF));
            chk("cout",   32'(bus.cout),   32'((full >> 8) & 1));
            chk("fa_idle", 32'({bus.fa_a, bus.fa_b, bus.fa_cin}), 32'd0);
         end
         if (chain && k >= DONE_CYC - 1) begin
            bus.start = 1'b1;
            bus.op_a  = na;
            bus.op_b  = nb;
            bus.cin   = nc;
         end else if (k == p1 || k == p2) begin
            bus.start = 1'b1;
            bus.op_a  = 8'h11;
            bus.op_b  = 8'h22;
            bus.cin   = 1'b0;
         end else begin
            bus.start = 1'b0;
            bus.op_a  = 8'($urandom);
            bus.op_b  = 8'($urandom);
            bus.cin   = 1'($urandom);
         end
         if (k == rst_at) reset = 1'b1;
         @(negedge clk);
      end
      if (!chain) begin
         chk("done_pulse_end", 32'(bus.done),   32'd0);
         chk("idle_busy",      32'(bus.busy),   32'd0);
         chk("result_held",    32'(bus.result), 32'(full & 8'hFF));
         chk("cout_held",      32'(bus.cout),   32'((full >> 8) & 1));
      end
   endtask

   initial begin
      logic [7:0] ra, rb;
      logic       rc;
      bus.start = 1'b0;
      bus.op_a  = '0;
      bus.op_b  = '0;
      bus.cin   = 1'b0;
      reset     = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_busy",   32'(bus.busy),   32'd0);
      chk("reset_done",   32'(bus.done),   32'd0);
      chk("reset_result", 32'(bus.result), 32'd0);
      chk("reset_cout",   32'(bus.cout),   32'd0);
      chk("reset_fa",     32'({bus.fa_a, bus.fa_b, bus.fa_cin}), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("idle_after_reset", 32'(bus.busy), 32'd0);

      // basic add
      issue(8'h35, 8'h4A, 1'b0);
      check_op(8'h35, 8'h4A, 1'b0, 0, 0, 0, 1'b0, 8'h00, 8'h00, 1'b0);
      // ripple carry through all bits
      issue(8'hFF, 8'h01, 1'b0);
      check_op(8'hFF, 8'h01, 1'b0, 0, 0, 0, 1'b0, 8'h00, 8'h00, 1'b0);
      // carry-in only
      issue(8'hFF, 8'h00, 1'b1);
      check_op(8'hFF, 8'h00, 1'b1, 0, 0, 0, 1'b0, 8'h00, 8'h00, 1'b0);
      // start pulses while busy are ignored
      issue(8'h35, 8'h4A, 1'b0);
      check_op(8'h35, 8'h4A, 1'b0, 5, 30, 0, 1'b0, 8'h00, 8'h00, 1'b0);
      // reset mid-operation
      issue(8'h35, 8'h4A, 1'b0);
      check_op(8'h35, 8'h4A, 1'b0, 0, 0, 20, 1'b0, 8'h00, 8'h00, 1'b0);
      // back-to-back via start held through the done cycle
      issue(8'h35, 8'h4A, 1'b0);
      check_op(8'h35, 8'h4A, 1'b0, 0, 0, 0, 1'b1, 8'h80, 8'h80, 1'b0);
      check_op(8'h80, 8'h80, 1'b0, 0, 0, 0, 1'b0, 8'h00, 8'h00, 1'b0);
      // randomized operands
      for (int n = 0; n < 6; n++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         rc = 1'($urandom);
         issue(ra, rb, rc);
         check_op(ra, rb, rc, int'($urandom_range(1, 47)), 0, 0, 1'b0, 8'h00, 8'h00, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
